pheromone_table_writer: RTL and testbench
=========================================

// Module: pheromone_table_writer
// PURPOSE
// - Registered owner/writer of the per-router ACO pheromone table. The output-port selection logic only reads this table.
// - Accepts reinforcement requests from the N input ports and arbitrates them round-robin.
// - Applies a saturating +1/-1 read-modify-write to one table row per accepted request.
// - Runs a periodic evaporation sweep that decays every entry one step toward PH_INIT.
// PARAMETERS
// X_LOC        0                  router X coordinate (informational; no functional use)
// Y_LOC        0                  router Y coordinate (informational; no functional use)
// EVAP_PERIOD  1024               cycles between evaporation sweeps; must be >= 2
// PH_INIT      `PH_MIN_VALUE      reset value of every entry and evaporation target
// PORTS
// clk              in   1                                 clock
// reset_n          in   1                                 asynchronous active-low reset
// i_update         in   [0:`N-1]                          per-input-port reinforcement request; held until acked
// i_x_dest         in   [0:`N-1][$clog2(`X_NODES)-1:0]    destination X of each request
// i_y_dest         in   [0:`N-1][$clog2(`Y_NODES)-1:0]    destination Y of each request
// o_update_ack     out  [0:`N-1]                          one-hot; request accepted this cycle
// o_pheromones     out  [0:`NODES-1][0:`N-2][`PH_TABLE_DEPTH-1:0]  registered table [dest row][out port-1]
// o_evap_active    out  1                                 high while in DRAIN or EVAP
// o_busy           out  1                                 write stage valid or o_evap_active
// BEHAVIOUR
// - Reset (async, immediate, also mid-operation): all entries = PH_INIT; rr_ptr = 0; write stage invalid;
//   period counter = 0; FSM = IDLE; o_update_ack, o_evap_active and o_busy all 0. Any in-flight update is lost.
// - Row computation: row = y_dest*`X_NODES + x_dest.
//   If row >= `NODES, the request is acked and then dropped (no write).
// - Arbitration (IDLE only):
//   - Grant the first requesting port at or after rr_ptr (circular, 0..`N-1).
//   - o_update_ack[g] is asserted combinationally in the same cycle.
//   - At the clock edge: capture (row, parent = g) into the write stage and set rr_ptr <= (g+1) mod `N.
//   - Requester must drop or replace i_update[g] in the cycle after its ack.
//   - At most one ack per cycle. A port not granted keeps its request and is never acked twice for one request.
// - Write stage: one cycle after the ack, at the clock edge, for each column j in 0..`N-2:
//   - if j+1 == parent: entry = min(entry+1, `PH_MAX_VALUE)
//   - otherwise:        entry = max(entry-1, `PH_MIN_VALUE)
//   - parent == 0 (local port) therefore decrements every column.
//   - Throughput is 1 update/cycle. Back-to-back updates to the same row see the previous write; no hazard logic is needed.
//   - Row written at edge t is visible on o_pheromones from edge t onward (table latency = 2 edges from ack cycle).
// - Evaporation FSM and counter:
//   - The period counter increments every cycle in IDLE.
//   - IDLE -> DRAIN when the counter reaches EVAP_PERIOD-1. The counter is cleared.
//   - DRAIN: no grants. Any valid write stage completes. -> EVAP in the next cycle (DRAIN always lasts exactly 1 cycle).
//   - EVAP: one row per cycle, rows 0..`NODES-1. Each entry moves 1 toward PH_INIT; entries already equal are unchanged.
//   - After the row `NODES-1 write -> IDLE. The counter restarts at 0.
//   - No acks in DRAIN or EVAP; requests stay pending until IDLE.
// - Saturation boundaries: values never leave [`PH_MIN_VALUE, `PH_MAX_VALUE]; no wrap-around.
// TESTING (bench cfg: N=5, X_NODES=Y_NODES=4, NODES=16, DEPTH=4, MIN=0, MAX=15, PH_INIT=0, EVAP_PERIOD=64)
// - Single request, port 2, dest (1,2) -> ack port 2 in the same cycle.
//   Next edge: row 9 = {0,1,0,0}. Other rows stay 0.
// - Port 1 held on row 3 for 20 consecutive acks -> row 3 col0 saturates at 15; col1..3 stay 0.
// - Ports 1,3,4 request simultaneously, rr_ptr=0 -> acks 1, 3, 4 in consecutive cycles; rr_ptr ends at 0.
// - Row 5 preset {15,3,0,7}, then 64 idle cycles -> o_evap_active high for 17 cycles (DRAIN + 16 rows).
//   Row 5 becomes {14,2,0,6}. A request raised during EVAP is acked in the first IDLE cycle.
// - Dest (3,3) port 4, then reset_n low for 1 cycle mid-sweep -> every entry 0 immediately, all outputs 0, no ack.
// - Port 0 on row 0 preset {2,2,2,2} -> row 0 = {1,1,1,1}.

Source files
------------

// File: rtl/pheromone_table_writer.sv
// Pheromone table owner: arbitrates reinforcement requests, applies
// saturating read-modify-write updates and runs periodic evaporation.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   i_update            per-input-port request, held until acked
//   i_x_dest, i_y_dest  destination coordinates of each request
//   o_update_ack        one-hot grant, combinational in the request cycle
//   o_pheromones        registered table [dest row][out port-1]
//   o_evap_active       high while draining or evaporating
//   o_busy              write stage valid or evaporation active

`ifndef N
`define N 5
`endif
`ifndef X_NODES
`define X_NODES 4
`endif
`ifndef Y_NODES
`define Y_NODES 4
`endif
`ifndef NODES
`define NODES 16
`endif
`ifndef PH_TABLE_DEPTH
`define PH_TABLE_DEPTH 4
`endif
`ifndef PH_MIN_VALUE
`define PH_MIN_VALUE 0
`endif
`ifndef PH_MAX_VALUE
`define PH_MAX_VALUE 15
`endif

module pheromone_table_writer #(
   parameter int X_LOC       = 0,
   parameter int Y_LOC       = 0,
   parameter int EVAP_PERIOD = 1024,
   parameter int PH_INIT     = `PH_MIN_VALUE
) (
   input  logic clk,
   input  logic reset_n,
   input  logic [0:`N-1] i_update,
   input  logic [0:`N-1][$clog2(`X_NODES)-1:0] i_x_dest,
   input  logic [0:`N-1][$clog2(`Y_NODES)-1:0] i_y_dest,
   output logic [0:`N-1] o_update_ack,
   output logic [0:`NODES-1][0:`N-2][`PH_TABLE_DEPTH-1:0] o_pheromones,
   output logic o_evap_active,
   output logic o_busy
);

   localparam int N     = `N;
   localparam int NODES = `NODES;
   localparam int DEPTH = `PH_TABLE_DEPTH;
   localparam int PW    = (N > 1) ? $clog2(N) : 1;
   localparam int RW    = (NODES > 1) ? $clog2(NODES) : 1;
   localparam int RFW   = $clog2(`X_NODES * `Y_NODES) + 2;
   localparam int CW    = $clog2(EVAP_PERIOD);

   localparam logic [DEPTH-1:0] PH_MIN = DEPTH'(`PH_MIN_VALUE);
   localparam logic [DEPTH-1:0] PH_MAX = DEPTH'(`PH_MAX_VALUE);
   localparam logic [DEPTH-1:0] PH_TGT = DEPTH'(PH_INIT);

   // Coordinates are informational only; reject nonsense at elaboration.
   if (EVAP_PERIOD < 2 || X_LOC < 0 || Y_LOC < 0) begin : g_param_chk
      $error("pheromone_table_writer: bad parameter value");
   end

   typedef enum logic [1:0] {IDLE, DRAIN, EVAP} state_t;

   state_t state;
   state_t state_nxt;

   logic [0:NODES-1][0:N-2][DEPTH-1:0] tbl;

   logic [PW-1:0]  rr_ptr;
   logic [PW-1:0]  gnt;
   logic           gnt_vld;
   logic [RFW-1:0] row_full;

   logic           wr_valid;
   logic [RW-1:0]  wr_row;
   logic [PW-1:0]  wr_parent;

   logic [CW-1:0]  cnt;
   logic           cnt_wrap;
   logic [RW-1:0]  ev_row;
   logic           ev_last;

   // Round-robin search starting at rr_ptr; grants only in IDLE.
   always_comb begin
      int idx;
      gnt     = '0;
      gnt_vld = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!gnt_vld && state == IDLE && i_update[idx]) begin
            gnt_vld = 1'b1;
            gnt     = PW'(idx);
         end
      end
   end

   // Ack is suppressed while reset is asserted.
   always_comb begin
      o_update_ack = '0;
      if (gnt_vld && reset_n) o_update_ack[gnt] = 1'b1;
   end

   assign row_full = RFW'(i_y_dest[gnt]) * RFW'(`X_NODES)
                   + RFW'(i_x_dest[gnt]);

   assign cnt_wrap = (cnt == CW'(EVAP_PERIOD - 1));
   assign ev_last  = (ev_row == RW'(NODES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (cnt_wrap) state_nxt = DRAIN;
         DRAIN:   state_nxt = EVAP;
         EVAP:    if (ev_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NODES; r++)
            for (int j = 0; j < N-1; j++)
               tbl[r][j] <= PH_TGT;
         rr_ptr    <= '0;
         wr_valid  <= 1'b0;
         wr_row    <= '0;
         wr_parent <= '0;
         cnt       <= '0;
         ev_row    <= '0;
      end else begin
         // Out-of-range rows are acked but never written.
         wr_valid <= gnt_vld && (row_full < RFW'(NODES));
         if (gnt_vld) begin
            wr_row    <= row_full[RW-1:0];
            wr_parent <= gnt;
            rr_ptr    <= (int'(gnt) == N-1) ? '0 : gnt + 1'b1;
         end

         if (state == IDLE)
            cnt <= cnt_wrap ? '0 : cnt + 1'b1;

         if (state == EVAP)
            ev_row <= ev_last ? '0 : ev_row + 1'b1;

         // DRAIN guarantees the write stage is empty during EVAP.
         if (wr_valid) begin
            for (int j = 0; j < N-1; j++) begin
               if (j + 1 == int'(wr_parent))
                  tbl[wr_row][j] <= (tbl[wr_row][j] >= PH_MAX) ?
                                    PH_MAX : tbl[wr_row][j] + 1'b1;
               else
                  tbl[wr_row][j] <= (tbl[wr_row][j] <= PH_MIN) ?
                                    PH_MIN : tbl[wr_row][j] - 1'b1;
            end
         end else if (state == EVAP) begin
            for (int j = 0; j < N-1; j++) begin
               if (tbl[ev_row][j] > PH_TGT)
                  tbl[ev_row][j] <= tbl[ev_row][j] - 1'b1;
               else if (tbl[ev_row][j] < PH_TGT)
                  tbl[ev_row][j] <= tbl[ev_row][j] + 1'b1;
            end
         end
      end
   end

   assign o_pheromones  = tbl;
   assign o_evap_active = (state != IDLE);
   assign o_busy        = wr_valid | o_evap_active;

endmodule

// File: tb/tb_pheromone_table_writer.sv
// Directed testbench for pheromone_table_writer.
// N=5, 4x4 mesh, 4-bit entries 0..15, EVAP_PERIOD=64.

`ifndef N
`define N 5
`endif
`ifndef X_NODES
`define X_NODES 4
`endif
`ifndef Y_NODES
`define Y_NODES 4
`endif
`ifndef NODES
`define NODES 16
`endif
`ifndef PH_TABLE_DEPTH
`define PH_TABLE_DEPTH 4
`endif
`ifndef PH_MIN_VALUE
`define PH_MIN_VALUE 0
`endif
`ifndef PH_MAX_VALUE
`define PH_MAX_VALUE 15
`endif

module tb_pheromone_table_writer;

   localparam int N     = `N;
   localparam int NODES = `NODES;
   localparam int DEPTH = `PH_TABLE_DEPTH;

   typedef logic [0:NODES-1][0:N-2][DEPTH-1:0] tbl_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [0:N-1] upd = '0;
   logic [0:N-1][1:0] xd = '0;
   logic [0:N-1][1:0] yd = '0;
   logic [0:N-1] ack;
   tbl_t ph;
   logic evap_active;
   logic busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pheromone_table_writer #(
      .X_LOC(0),
      .Y_LOC(0),
      .EVAP_PERIOD(64),
      .PH_INIT(0)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .i_update(upd),
      .i_x_dest(xd),
      .i_y_dest(yd),
      .o_update_ack(ack),
      .o_pheromones(ph),
      .o_evap_active(evap_active),
      .o_busy(busy)
   );

   function automatic logic [0:N-1] onehot(input int p);
      logic [0:N-1] v;
      v = '0;
      if (p >= 0) v[p] = 1'b1;
      return v;
   endfunction

   task automatic set_req(input int p, input int x, input int y);
      upd[p] = 1'b1;
      xd[p]  = 2'(x);
      yd[p]  = 2'(y);
   endtask

   task automatic do_reset();
      @(negedge clk);
      upd = '0;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      tbl_t e;
      e = '0;
      @(negedge clk);
      upd = '0;
      reset_n = 1'b0;
      #1;
      checks++;
      if (ack !== '0 || busy !== 1'b0 || evap_active !== 1'b0) begin
         errors++;
         $display("FAIL reset_outs ack=%b busy=%b evap=%b want 0",
                  ack, busy, evap_active);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (ph !== e) begin
         errors++;
         $display("FAIL reset_table got %h want %h", ph, e);
      end
   endtask

   task automatic test_single();
      tbl_t e;
      do_reset();
      set_req(2, 1, 2);
      #1;
      checks++;
      if (ack !== onehot(2)) begin
         errors++;
         $display("FAIL single_ack got %b want %b", ack, onehot(2));
      end
      @(negedge clk);
      upd = '0;
      e = '0;
      checks++;
      if (busy !== 1'b1 || ph !== e) begin
         errors++;
         $display("FAIL single_lat busy=%b tbl=%h want busy 1 tbl %h",
                  busy, ph, e);
      end
      @(negedge clk);
      e[9] = {4'd0, 4'd1, 4'd0, 4'd0};
      checks++;
      if (ph !== e || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_row9 got %h busy=%b want %h busy 0",
                  ph, busy, e);
      end
   endtask

   task automatic test_saturate();
      tbl_t e;
      do_reset();
      set_req(1, 3, 0);
      for (int i = 0; i < 20; i++) begin
         #1;
         checks++;
         if (ack !== onehot(1)) begin
            errors++;
            $display("FAIL sat_ack%0d got %b want %b", i, ack, onehot(1));
         end
         @(negedge clk);
      end
      upd = '0;
      @(negedge clk);
      e = '0;
      e[3] = {4'd15, 4'd0, 4'd0, 4'd0};
      checks++;
      if (ph !== e) begin
         errors++;
         $display("FAIL sat_row3 got %h want %h", ph, e);
      end
      set_req(0, 3, 0);
      #1;
      checks++;
      if (ack !== onehot(0)) begin
         errors++;
         $display("FAIL local_ack got %b want %b", ack, onehot(0));
      end
      @(negedge clk);
      upd = '0;
      @(negedge clk);
      e[3] = {4'd14, 4'd0, 4'd0, 4'd0};
      checks++;
      if (ph !== e) begin
         errors++;
         $display("FAIL local_row3 got %h want %h", ph, e);
      end
   endtask

   task automatic test_round_robin();
      tbl_t e;
      int order [5];
      do_reset();
      set_req(1, 0, 1);
      set_req(3, 1, 1);
      set_req(4, 2, 1);
      order = '{1, 3, 4, 0, 4};
      for (int k = 0; k < 5; k++) begin
         if (k == 3) begin
            #1;
            checks++;
            if (ack !== '0) begin
               errors++;
               $display("FAIL rr_idle got %b want 0", ack);
            end
            @(negedge clk);
            set_req(0, 3, 1);
            set_req(4, 0, 2);
         end
         #1;
         checks++;
         if (ack !== onehot(order[k])) begin
            errors++;
            $display("FAIL rr_ack%0d got %b want %b",
                     k, ack, onehot(order[k]));
         end
         @(negedge clk);
         upd[order[k]] = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      e = '0;
      e[4] = {4'd1, 4'd0, 4'd0, 4'd0};
      e[5] = {4'd0, 4'd0, 4'd1, 4'd0};
      e[6] = {4'd0, 4'd0, 4'd0, 4'd1};
      e[8] = {4'd0, 4'd0, 4'd0, 4'd1};
      checks++;
      if (ph !== e) begin
         errors++;
         $display("FAIL rr_table got %h want %h", ph, e);
      end
   endtask

   task automatic test_evap();
      tbl_t e;
      int n;
      int len;
      do_reset();
      n = 0;
      @(negedge clk);
      n++;
      set_req(1, 1, 1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n++;
      end
      upd[1] = 1'b0;
      set_req(4, 1, 1);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (ack !== onehot(4)) begin
            errors++;
            $display("FAIL evap_pre_ack got %b want %b", ack, onehot(4));
         end
         @(negedge clk);
         n++;
      end
      upd = '0;
      @(negedge clk);
      n++;
      e = '0;
      e[5] = {4'd12, 4'd0, 4'd0, 4'd3};
      checks++;
      if (ph !== e || evap_active !== 1'b0) begin
         errors++;
         $display("FAIL evap_preset got %h evap=%b want %h evap 0",
                  ph, evap_active, e);
      end
      while (!evap_active && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== 64) begin
         errors++;
         $display("FAIL evap_start got cycle %0d want 64", n);
      end
      len = 0;
      while (evap_active && len < 40) begin
         len++;
         checks++;
         if (ack !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL evap_noack ack=%b busy=%b want 0 and 1",
                     ack, busy);
         end
         if (len == 3) set_req(3, 1, 0);
         @(negedge clk);
      end
      checks++;
      if (len !== 17) begin
         errors++;
         $display("FAIL evap_len got %0d want 17", len);
      end
      checks++;
      if (ack !== onehot(3)) begin
         errors++;
         $display("FAIL evap_first_idle_ack got %b want %b",
                  ack, onehot(3));
      end
      @(negedge clk);
      upd = '0;
      @(negedge clk);
      e[5] = {4'd11, 4'd0, 4'd0, 4'd2};
      e[1] = {4'd0, 4'd0, 4'd1, 4'd0};
      checks++;
      if (ph !== e || busy !== 1'b0) begin
         errors++;
         $display("FAIL evap_table got %h busy=%b want %h busy 0",
                  ph, busy, e);
      end
   endtask

   task automatic test_reset_mid();
      tbl_t e;
      int m;
      do_reset();
      set_req(4, 3, 3);
      #1;
      checks++;
      if (ack !== onehot(4)) begin
         errors++;
         $display("FAIL mid_ack got %b want %b", ack, onehot(4));
      end
      @(negedge clk);
      upd = '0;
      @(negedge clk);
      e = '0;
      e[15] = {4'd0, 4'd0, 4'd0, 4'd1};
      checks++;
      if (ph !== e) begin
         errors++;
         $display("FAIL mid_row15 got %h want %h", ph, e);
      end
      m = 0;
      while (!evap_active && m < 100) begin
         @(negedge clk);
         m++;
      end
      checks++;
      if (evap_active !== 1'b1) begin
         errors++;
         $display("FAIL mid_evap_timeout evap=%b want 1", evap_active);
      end
      repeat (5) @(negedge clk);
      set_req(2, 0, 0);
      reset_n = 1'b0;
      #1;
      e = '0;
      checks++;
      if (ph !== e) begin
         errors++;
         $display("FAIL mid_rst_table got %h want %h", ph, e);
      end
      checks++;
      if (ack !== '0 || busy !== 1'b0 || evap_active !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst_outs ack=%b busy=%b evap=%b want 0",
                  ack, busy, evap_active);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checks++;
      if (ack !== onehot(2)) begin
         errors++;
         $display("FAIL mid_post_ack got %b want %b", ack, onehot(2));
      end
      @(negedge clk);
      upd = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_saturate();
      test_round_robin();
      test_evap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
